// File: rtl/bldc_pwm_commutator_if.sv
// Signal bundle between the motor-control sequencer and the BLDC gate driver.
// The controller side drives commands and Hall inputs; the commutator drives
// gates, the period strobe, the fault flag and debug state.
// Handshake contract: there is no valid/ready pair on this bundle. Commands are
// level-sampled every clk. clk_20k_enable is a one-cycle strobe that carries no
// backpressure, so the consumer must act in the cycle it is high.
`timescale 1ns/1ps
interface bldc_pwm_commutator_if;
  logic        enable;
  logic [15:0] vref_q15;
  logic        dir;
  logic [2:0]  hall;
  logic        fault_clr;
  logic        pwm_ah;
  logic        pwm_al;
  logic        pwm_bh;
  logic        pwm_bl;
  logic        pwm_ch;
  logic        pwm_cl;
  logic        clk_20k_enable;
  logic        hall_fault;
  logic [15:0] dbg_cnt;
  logic [15:0] dbg_duty;
  logic [5:0]  dbg_leg_state;

  modport master (
    output enable, vref_q15, dir, hall, fault_clr,
    input  pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl,
    input  clk_20k_enable, hall_fault, dbg_cnt, dbg_duty, dbg_leg_state
  );

  modport slave (
    input  enable, vref_q15, dir, hall, fault_clr,
    output pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch, pwm_cl,
    output clk_20k_enable, hall_fault, dbg_cnt, dbg_duty, dbg_leg_state
  );
endinterface

// File: rtl/bldc_pwm_commutator.sv
// Six-step Hall-commutated BLDC gate driver with edge-aligned PWM chop on the
// high side, a per-leg OFF/HI/LO state machine enforcing dead time, and a
// latched invalid-Hall fault. PWM_PERIOD must not exceed 65535.
// Debug: dbg_leg_state = {leg C, leg B, leg A}, 2 bits each (00 OFF, 01 HI, 10 LO).
`timescale 1ns/1ps
module bldc_pwm_commutator #(
  parameter int PWM_PERIOD = 5000,
  parameter int DEAD_TIME  = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bldc_pwm_commutator_if.slave  bus
);

  localparam logic [15:0] CNT_LAST = 16'(PWM_PERIOD - 1);
  localparam int          DW       = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);
  localparam logic [DW-1:0] DT_SAT = DW'(DEAD_TIME);

  localparam logic [1:0] S_OFF = 2'b00;
  localparam logic [1:0] S_HI  = 2'b01;
  localparam logic [1:0] S_LO  = 2'b10;

  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;

  logic [15:0] cnt;
  logic [15:0] duty_sh;
  logic [15:0] duty_next;
  logic [15:0] vref_clamped;
  logic        period_end;
  logic        chop;
  logic [2:0]  hall_s1;
  logic [2:0]  hall_s2;
  logic        hall_valid;
  logic        hall_fault;
  logic        drive_ok;
  logic [1:0]  pos_fwd;
  logic [1:0]  neg_fwd;
  logic [1:0]  pos_ph;
  logic [1:0]  neg_ph;
  logic [2:0]  gate_h;
  logic [2:0]  gate_l;
  logic [5:0]  state_flat;

  assign period_end = (cnt == CNT_LAST);

  // Free-running period counter, independent of enable and fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        cnt <= '0;
    else if (period_end) cnt <= '0;
    else                 cnt <= cnt + 16'd1;
  end

  // Magnitudes at or above 1.0 are clamped to the largest positive Q1.15.
  assign vref_clamped = bus.vref_q15[15] ? 16'h7FFF : bus.vref_q15;
  assign duty_next    = 16'(({16'd0, vref_clamped} * 32'(PWM_PERIOD)) >> 15);

  // Duty is sampled once per period so mid-period command changes cannot glitch the chop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        duty_sh <= '0;
    else if (period_end) duty_sh <= duty_next;
  end

  assign chop = (cnt < duty_sh);

  // Two-flop synchronizer for the asynchronous Hall inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_s1 <= '0;
      hall_s2 <= '0;
    end else begin
      hall_s1 <= bus.hall;
      hall_s2 <= hall_s1;
    end
  end

  assign hall_valid = (hall_s2 != 3'b000) && (hall_s2 != 3'b111);

  // Fault latches on any invalid code; clearing needs both the request and a valid code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         hall_fault <= 1'b0;
    else if (!hall_valid) hall_fault <= 1'b1;
    else if (bus.fault_clr) hall_fault <= 1'b0;
  end

  assign drive_ok = bus.enable && !hall_fault && hall_valid;

  // Forward six-step table; reverse simply swaps the driven and return phases.
  always_comb begin
    pos_fwd = PH_A;
    neg_fwd = PH_B;
    case (hall_s2)
      3'b101:  begin pos_fwd = PH_A; neg_fwd = PH_B; end
      3'b100:  begin pos_fwd = PH_A; neg_fwd = PH_C; end
      3'b110:  begin pos_fwd = PH_B; neg_fwd = PH_C; end
      3'b010:  begin pos_fwd = PH_B; neg_fwd = PH_A; end
      3'b011:  begin pos_fwd = PH_C; neg_fwd = PH_A; end
      3'b001:  begin pos_fwd = PH_C; neg_fwd = PH_B; end
      default: begin pos_fwd = PH_A; neg_fwd = PH_B; end
    endcase
    pos_ph = bus.dir ? pos_fwd : neg_fwd;
    neg_ph = bus.dir ? neg_fwd : pos_fwd;
  end

  for (genvar g = 0; g < 3; g++) begin : g_leg
    logic [1:0]    req;
    logic [1:0]    state;
    logic [DW-1:0] dt;

    // Leg request: chopped high side on the driven phase, solid low side on the return phase.
    always_comb begin
      req = S_OFF;
      if (drive_ok) begin
        if (pos_ph == 2'(g))      req = chop ? S_HI : S_OFF;
        else if (neg_ph == 2'(g)) req = S_LO;
      end
    end

    // Leg FSM: any change leaves via OFF, and OFF is held until the dead-time counter saturates.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= S_OFF;
        dt    <= '0;
      end else begin
        case (state)
          S_OFF: begin
            if ((dt >= DT_SAT) && (req != S_OFF)) begin
              state <= req;
              dt    <= '0;
            end else if (dt < DT_SAT) begin
              dt <= dt + DW'(1);
            end
          end
          S_HI, S_LO: begin
            if (req != state) begin
              state <= S_OFF;
              dt    <= '0;
            end
          end
          default: begin
            state <= S_OFF;
            dt    <= '0;
          end
        endcase
      end
    end

    assign gate_h[g]            = (state == S_HI);
    assign gate_l[g]            = (state == S_LO);
    assign state_flat[2*g +: 2] = state;
  end

  assign bus.pwm_ah         = gate_h[0];
  assign bus.pwm_al         = gate_l[0];
  assign bus.pwm_bh         = gate_h[1];
  assign bus.pwm_bl         = gate_l[1];
  assign bus.pwm_ch         = gate_h[2];
  assign bus.pwm_cl         = gate_l[2];
  assign bus.clk_20k_enable = period_end;
  assign bus.hall_fault     = hall_fault;
  assign bus.dbg_cnt        = cnt;
  assign bus.dbg_duty       = duty_sh;
  assign bus.dbg_leg_state  = state_flat;

endmodule

// File: tb/tb_bldc_pwm_commutator.sv
// Directed bench for bldc_pwm_commutator: period/strobe timing, duty shadowing,
// clamp, six-step tables in both directions, Hall fault, async reset, and
// continuous monitors for gate overlap and dead-time gaps.
`timescale 1ns/1ps
module tb_bldc_pwm_commutator;

  localparam int PWM_PERIOD = 5000;
  localparam int DEAD_TIME  = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bldc_pwm_commutator_if bus();

  bldc_pwm_commutator #(.PWM_PERIOD(PWM_PERIOD), .DEAD_TIME(DEAD_TIME)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [5:0] gates;
  assign gates = {bus.pwm_ah, bus.pwm_al, bus.pwm_bh, bus.pwm_bl, bus.pwm_ch, bus.pwm_cl};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int off_len [3];
  logic was_on [3];
  int gap_events  = 0;
  int short_gaps  = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    logic [2:0] on_v;
    on_v = {bus.pwm_ch | bus.pwm_cl, bus.pwm_bh | bus.pwm_bl, bus.pwm_ah | bus.pwm_al};
    if ((bus.pwm_ah & bus.pwm_al) | (bus.pwm_bh & bus.pwm_bl) | (bus.pwm_ch & bus.pwm_cl))
      overlap_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        off_len[i] = 0;
        was_on[i]  = 1'b0;
      end else begin
        if (on_v[i] && !was_on[i]) begin
          gap_events++;
          if (off_len[i] < DEAD_TIME) short_gaps++;
        end
        if (on_v[i]) off_len[i] = 0;
        else         off_len[i] = off_len[i] + 1;
        was_on[i] = on_v[i];
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [15:0] vref, input logic d, input logic [2:0] h);
    bus.enable   = en;
    bus.vref_q15 = vref;
    bus.dir      = d;
    bus.hall     = h;
  endtask

  // Leaves the bench at the negedge sample where the counter equals target.
  task automatic wait_cnt(input int target);
    int n = 0;
    @(negedge clk);
    while (bus.dbg_cnt != 16'(target) && n < 2 * PWM_PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (bus.dbg_cnt != 16'(target)) check_eq("wait_cnt_timeout", 32'(bus.dbg_cnt), 32'(target));
  endtask

  task automatic measure(input int n, output int ah_n, output int bl_n, output int stb_n,
                         output logic [5:0] seen);
    ah_n = 0; bl_n = 0; stb_n = 0; seen = '0;
    for (int i = 0; i < n; i++) begin
      if (bus.pwm_ah) ah_n++;
      if (bus.pwm_bl) bl_n++;
      if (bus.clk_20k_enable) stb_n++;
      seen = seen | gates;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] hall_seq [6];
  logic [5:0] fwd_exp  [6];
  logic [5:0] rev_exp  [6];

  initial begin
    int ah_n, bl_n, stb_n, n;
    logic [5:0] seen;

    hall_seq = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    fwd_exp  = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
    rev_exp  = '{6'b011000, 6'b010010, 6'b000110, 6'b100100, 6'b100001, 6'b001001};

    drive(1'b1, 16'h4000, 1'b1, 3'b101);
    bus.fault_clr = 1'b1;

    // Reset state
    #22;
    check_eq("rst_gates", 32'(gates), 0);
    check_eq("rst_strobe", 32'(bus.clk_20k_enable), 0);
    check_eq("rst_fault", 32'(bus.hall_fault), 0);
    check_eq("rst_cnt", 32'(bus.dbg_cnt), 0);
    check_eq("rst_duty", 32'(bus.dbg_duty), 0);
    check_eq("rst_legs", 32'(bus.dbg_leg_state), 0);

    @(negedge clk); #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("cnt_after_release", 32'(bus.dbg_cnt), 10);
    bus.fault_clr = 1'b0;
    check_eq("fault_after_init", 32'(bus.hall_fault), 0);

    // 50% duty, hall 101 forward: A chops, B low side solid
    wait_cnt(0);
    check_eq("duty_4000", 32'(bus.dbg_duty), 2500);
    measure(PWM_PERIOD, ah_n, bl_n, stb_n, seen);
    check_eq("ah_on_4000", 32'(ah_n), 2500);
    check_eq("bl_on_4000", 32'(bl_n), 5000);
    check_eq("strobes_per_period", 32'(stb_n), 1);
    check_eq("gates_seen_4000", 32'(seen), 32'(6'b100100));

    n = 0;
    while (!bus.clk_20k_enable && n < 2 * PWM_PERIOD) begin @(negedge clk); n++; end
    check_eq("strobe_at_last_count", 32'(n), 4999);
    @(negedge clk); n = 1;
    while (!bus.clk_20k_enable && n < 2 * PWM_PERIOD) begin @(negedge clk); n++; end
    check_eq("strobe_interval", 32'(n), 5000);

    // Asynchronous reset mid-period with A high side on
    wait_cnt(1500);
    check_eq("ah_before_reset", 32'(bus.pwm_ah), 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("reset_gates_drop", 32'(gates), 0);
    check_eq("reset_cnt_zero", 32'(bus.dbg_cnt), 0);
    check_eq("reset_duty_zero", 32'(bus.dbg_duty), 0);
    check_eq("reset_legs_off", 32'(bus.dbg_leg_state), 0);
    bus.fault_clr = 1'b1;
    @(negedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_eq("cnt_restart", 32'(bus.dbg_cnt), 1);
    measure(DEAD_TIME, ah_n, bl_n, stb_n, seen);
    check_eq("gates_quiet_after_reset", 32'(seen), 0);
    bus.fault_clr = 1'b0;
    check_eq("fault_after_reset", 32'(bus.hall_fault), 0);

    // Duty shadow: change at counter 1000 takes effect next period
    bus.vref_q15 = 16'h2000;
    wait_cnt(0);
    check_eq("duty_2000", 32'(bus.dbg_duty), 1250);
    wait_cnt(1000);
    bus.vref_q15 = 16'h6000;
    check_eq("duty_held_mid", 32'(bus.dbg_duty), 1250);
    measure(PWM_PERIOD - 1000, ah_n, bl_n, stb_n, seen);
    check_eq("ah_rest_of_period", 32'(ah_n), 251);
    check_eq("duty_6000", 32'(bus.dbg_duty), 3750);
    measure(PWM_PERIOD, ah_n, bl_n, stb_n, seen);
    check_eq("ah_on_6000", 32'(ah_n), 3750);

    // Clamp: FFFF -> 4999; the 1-cycle chop gap is widened by dead time
    bus.vref_q15 = 16'hFFFF;
    wait_cnt(0);
    check_eq("duty_clamp", 32'(bus.dbg_duty), 4999);
    measure(PWM_PERIOD, ah_n, bl_n, stb_n, seen);
    check_eq("ah_clamp_first", 32'(ah_n), 4999);
    measure(PWM_PERIOD, ah_n, bl_n, stb_n, seen);
    check_eq("ah_clamp_steady", 32'(ah_n), 4899);
    check_eq("bl_clamp_steady", 32'(bl_n), 5000);

    // Commutation tables, forward then reverse
    for (int i = 0; i < 6; i++) exp_q.push_back(fwd_exp[i]);
    for (int i = 0; i < 6; i++) exp_q.push_back(rev_exp[i]);
    for (int d = 1; d >= 0; d--) begin
      bus.dir = d[0];
      for (int i = 0; i < 6; i++) begin
        bus.hall = hall_seq[i];
        repeat (300) @(negedge clk);
        measure(300, ah_n, bl_n, stb_n, seen);
        check_eq($sformatf("commutation_dir%0d_hall%03b", d, hall_seq[i]), 32'(seen),
                 32'(exp_q.pop_front()));
      end
    end
    bus.dir  = 1'b1;
    bus.hall = 3'b101;

    // Zero duty: no high side at all, low side solid
    bus.vref_q15 = 16'h0000;
    repeat (300) @(negedge clk);
    wait_cnt(0);
    check_eq("duty_zero", 32'(bus.dbg_duty), 0);
    measure(PWM_PERIOD, ah_n, bl_n, stb_n, seen);
    check_eq("ah_zero_duty", 32'(ah_n), 0);
    check_eq("bl_zero_duty", 32'(bl_n), 5000);
    check_eq("gates_seen_zero", 32'(seen), 32'(6'b000100));

    // Hall fault
    bus.hall = 3'b111;
    repeat (3) @(negedge clk);
    check_eq("fault_set", 32'(bus.hall_fault), 1);
    check_eq("fault_gates_off", 32'(gates), 0);
    bus.fault_clr = 1'b1;
    repeat (5) @(negedge clk);
    bus.fault_clr = 1'b0;
    check_eq("fault_sticky", 32'(bus.hall_fault), 1);
    bus.hall = 3'b011;
    bus.fault_clr = 1'b1;
    repeat (5) @(negedge clk);
    bus.fault_clr = 1'b0;
    check_eq("fault_cleared", 32'(bus.hall_fault), 0);
    repeat (200) @(negedge clk);
    check_eq("gates_resume", 32'(gates), 32'(6'b010000));

    // Monitor results
    check_eq("overlap_count", 32'(overlap_cnt), 0);
    check_eq("short_dead_gaps", 32'(short_gaps), 0);
    check_eq("gap_events_seen", 32'(gap_events > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bldc_pwm_commutator.md
BLDC_PWM_COMMUTATOR -- requirements
Module: bldc_pwm_commutator

Interface
REQ-001 The block SHALL have parameter PWM_PERIOD, default 5000, meaning clk cycles per PWM period (100 MHz / 20 kHz).
REQ-002 The block SHALL have parameter DEAD_TIME, default 100, meaning the minimum number of clk cycles a leg stays fully off between gate changes.
REQ-003 The block SHALL have port clk, input, 1 bit: 100 MHz system clock, the only clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: gate drive enable.
REQ-006 The block SHALL have port vref_q15, input, 16 bits: voltage magnitude command (Q1.15) from the current PI stage.
REQ-007 The block SHALL have port dir, input, 1 bit: 1 = forward, 0 = reverse.
REQ-008 The block SHALL have port hall, input, 3 bits: asynchronous Hall sensors {A,B,C}.
REQ-009 The block SHALL have port fault_clr, input, 1 bit: clears hall_fault.
REQ-010 The block SHALL have ports pwm_ah, pwm_al, pwm_bh, pwm_bl, pwm_ch and pwm_cl, outputs, 1 bit each: high-side and low-side gate drives.
REQ-011 The block SHALL have port clk_20k_enable, output, 1 bit: one-cycle strobe per PWM period, consumed by the current controller.
REQ-012 The block SHALL have port hall_fault, output, 1 bit: latched invalid-Hall indication.

Function
REQ-013 The period counter SHALL count 0..PWM_PERIOD-1, wrap to 0, and run regardless of enable or fault.
REQ-014 clk_20k_enable SHALL be high for exactly the one cycle in which the counter equals PWM_PERIOD-1.
REQ-015 duty SHALL equal (min(vref_q15,16'h7FFF) * PWM_PERIOD) >> 15, computed unsigned with at least 32-bit width; vref_q15 >= 16'h8000 SHALL clamp to 16'h7FFF.
REQ-016 The duty shadow register SHALL load in the same cycle as clk_20k_enable and take effect from counter 0 of the next period; mid-period vref_q15 changes SHALL have no effect within the current period.
REQ-017 Chop SHALL be asserted when counter < duty shadow; duty 0 SHALL give no high-side on-time.
REQ-018 hall SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-019 Forward commutation SHALL be: 101 -> A+ B-; 100 -> A+ C-; 110 -> B+ C-; 010 -> B+ A-; 011 -> C+ A-; 001 -> C+ B-.
REQ-020 Reverse commutation SHALL swap the + and - phases of each forward entry (e.g. 101 -> B+ A-).
REQ-021 The "+" leg SHALL request HI while chop is asserted and OFF otherwise; the "-" leg SHALL request LO for the whole period; the third leg SHALL request OFF.
REQ-022 Synchronized hall of 000 or 111 SHALL set hall_fault on the next cycle; hall_fault SHALL clear only while fault_clr = 1 and synchronized hall is valid.
REQ-023 All legs SHALL request OFF while enable = 0 or hall_fault = 1.
REQ-024 Each leg SHALL be a state machine with states OFF, HI and LO; in HI only the leg's xh output is 1, in LO only its xl output is 1, and in OFF both are 0.
REQ-025 HI or LO SHALL go to OFF in the cycle after the request differs from the current state.
REQ-026 OFF SHALL go to the requested HI or LO only once the leg has been OFF for at least DEAD_TIME consecutive cycles, tracked by a per-leg saturating counter.
REQ-027 xh and xl SHALL never be 1 simultaneously, under any input sequence.
REQ-028 A direct HI <-> LO change SHALL always pass through OFF for at least DEAD_TIME cycles.
REQ-029 A chop pulse shorter than the dead-time recovery SHALL be absorbed (no high-side pulse); this is accepted behaviour.

Reset
REQ-030 While reset_n = 0, all gate outputs SHALL be 0, clk_20k_enable 0, hall_fault 0, counter 0, duty shadow 0, synchronizer flops 0, and all legs OFF with dead-time counters at 0.
REQ-031 Reset assertion SHALL force all gates to 0 asynchronously, mid-period or mid-dead-time.
REQ-032 After reset release, no gate SHALL assert before DEAD_TIME cycles have elapsed.

Verification
REQ-033 Bench SHALL cover: vref_q15 = 16'h4000, hall = 101, dir = 1, enable = 1 -> pwm_ah high about 2500 cycles per 5000-cycle period (less the dead-time delay), pwm_bl continuously high, clk_20k_enable every 5000 cycles.
REQ-034 Bench SHALL cover: vref_q15 changed from 16'h2000 to 16'h6000 at counter 1000 -> current period keeps duty 1250, next period uses 3750.
REQ-035 Bench SHALL cover: hall stepped through the full forward sequence, then dir toggled -> gates match the REQ-019/020 tables, each leg change shows >= 100 cycles of both-off, and the xh&xl overlap assertion never fires.
REQ-036 Bench SHALL cover: hall = 111 -> hall_fault = 1 and all gates 0 within 3 cycles; fault_clr pulsed while hall = 111 -> stays faulted; fault_clr with hall = 011 -> clears, and gates resume after DEAD_TIME.
REQ-037 Bench SHALL cover: vref_q15 = 16'hFFFF -> duty clamps to 4999; vref_q15 = 0 -> pwm_xh never asserts, low side unaffected.
REQ-038 Bench SHALL cover: reset_n pulsed low mid-period with pwm_ah = 1 -> all gates drop immediately, counter restarts at 0.
